// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds one shared UART transmitter from NUM_REQ byte producers,
// with optional burst hold and a watchdog on the txStart -> txBusy handshake.
`timescale 1ns/1ps
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int BURST_LEN     = 1,
    parameter int START_TIMEOUT = 4096
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 enable,
    input  logic [NUM_REQ-1:0]   reqValid,
    input  logic [8*NUM_REQ-1:0] reqData,
    output logic [NUM_REQ-1:0]   reqReady,
    output logic                 uartTxEn,
    output logic                 uartTxStart,
    output logic [7:0]           uartTxIn,
    input  logic                 uartTxBusy,
    input  logic                 uartTxDone,
    output logic [2:0]           grantId,
    output logic                 busy,
    output logic                 timeoutErr
);

    localparam int TW = (START_TIMEOUT > 2) ? $clog2(START_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SEND  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           rr_ptr_q, rr_ptr_d;
    logic [2:0]           grant_q, grant_d;
    logic [3:0]           burst_cnt_q, burst_cnt_d;
    logic [TW-1:0]        tmo_cnt_q, tmo_cnt_d;
    logic [NUM_REQ-1:0]   ready_q, ready_d;
    logic [7:0]           tx_in_q, tx_in_d;
    logic                 tx_start_q, tx_start_d;
    logic                 busy_q, busy_d;
    logic                 tmo_err_q, tmo_err_d;
    logic                 tx_en_q;

    logic                 grant_vld;
    logic                 burst_more;
    logic                 rr_found;
    logic [2:0]           rr_win;
    logic [2:0]           win;
    logic [2:0]           win_next;
    logic [7:0]           win_dat;
    logic [NUM_REQ-1:0]   win_onehot;
    logic                 unused_done;

    // Completion is tracked through txBusy; txDone is only observed.
    assign unused_done = uartTxDone;

    always_comb begin
        grant_vld = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == 3'(i)) begin
                grant_vld = reqValid[i];
            end
        end

        // Lowest valid index at or above the pointer wins; otherwise wrap to lowest valid.
        rr_found = 1'b0;
        rr_win   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (reqValid[i] && (3'(i) >= rr_ptr_q)) begin
                rr_found = 1'b1;
                rr_win   = 3'(i);
            end
        end
        if (!rr_found) begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (reqValid[i]) begin
                    rr_win = 3'(i);
                end
            end
        end

        burst_more = (burst_cnt_q != 4'd0) && (burst_cnt_q < 4'(BURST_LEN)) && grant_vld;
        win        = burst_more ? grant_q : rr_win;
        win_next   = (win == 3'(NUM_REQ - 1)) ? 3'd0 : win + 3'd1;

        win_dat    = '0;
        win_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == 3'(i)) begin
                win_dat       = reqData[8*i +: 8];
                win_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        burst_cnt_d = burst_cnt_q;
        tmo_cnt_d   = '0;
        ready_d     = '0;
        tx_in_d     = tx_in_q;
        tx_start_d  = tx_start_q;
        tmo_err_d   = tmo_err_q;

        case (state_q)
            IDLE: begin
                if (enable && (|reqValid)) begin
                    ready_d    = win_onehot;
                    grant_d    = win;
                    tx_in_d    = win_dat;
                    tx_start_d = 1'b1;
                    state_d    = START;
                    if (burst_more) begin
                        burst_cnt_d = burst_cnt_q + 4'd1;
                    end else begin
                        burst_cnt_d = 4'd1;
                        rr_ptr_d    = win_next;
                    end
                end else if (!grant_vld) begin
                    burst_cnt_d = 4'd0;
                end
            end
            START: begin
                // A frame already under way takes priority over enable loss or timeout.
                if (uartTxBusy) begin
                    tx_start_d = 1'b0;
                    state_d    = SEND;
                end else if (!enable) begin
                    tx_start_d = 1'b0;
                    state_d    = IDLE;
                end else if (tmo_cnt_q == TW'(START_TIMEOUT - 1)) begin
                    tmo_err_d  = 1'b1;
                    tx_start_d = 1'b0;
                    state_d    = IDLE;
                end else begin
                    tmo_cnt_d  = tmo_cnt_q + 1'b1;
                end
            end
            SEND: begin
                if (!uartTxBusy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                tx_start_d = 1'b0;
                state_d    = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            burst_cnt_q <= '0;
            tmo_cnt_q   <= '0;
            ready_q     <= '0;
            tx_in_q     <= '0;
            tx_start_q  <= 1'b0;
            busy_q      <= 1'b0;
            tmo_err_q   <= 1'b0;
            tx_en_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            burst_cnt_q <= burst_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            ready_q     <= ready_d;
            tx_in_q     <= tx_in_d;
            tx_start_q  <= tx_start_d;
            busy_q      <= busy_d;
            tmo_err_q   <= tmo_err_d;
            tx_en_q     <= enable;
        end
    end

    assign reqReady    = ready_q;
    assign uartTxEn    = tx_en_q;
    assign uartTxStart = tx_start_q;
    assign uartTxIn    = tx_in_q;
    assign grantId     = grant_q;
    assign busy        = busy_q;
    assign timeoutErr  = tmo_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: two instances (pure round-robin and burst of 3) share stimulus,
// each talking to a simple far-end UART model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int TO    = 16;
    localparam int FRAME = 4;
    localparam int BL_A  = 1;
    localparam int BL_B  = 3;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           enable = 1'b0;
    logic [N-1:0]   req_vld = '0;
    logic [8*N-1:0] req_dat = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    logic           ub_a = 1'b0, ub_b = 1'b0, ud_a = 1'b0, ud_b = 1'b0;
    logic           dead = 1'b0;

    logic [N-1:0] a_rdy, b_rdy;
    logic         a_en, b_en, a_st, b_st, a_bsy, b_bsy, a_err, b_err;
    logic [7:0]   a_tin, b_tin;
    logic [2:0]   a_gid, b_gid;

    int tests = 0;
    int fails = 0;
    int log_a[$], log_b[$];
    logic [7:0] rx_a[$], rx_b[$];
    int left_a = 0, left_b = 0;

    // Reference model state, one slot per instance.
    int         ph[2], ptr[2], run[2], own[2], age[2];
    logic [7:0] m_dat[2];
    logic [3:0] m_rdy[2];
    logic       m_st[2], m_err[2], m_en[2];

    uart_tx_arbiter #(.NUM_REQ(N), .BURST_LEN(BL_A), .START_TIMEOUT(TO)) dut_a (
        .clk(clk), .rstn(rstn), .enable(enable), .reqValid(req_vld), .reqData(req_dat),
        .reqReady(a_rdy), .uartTxEn(a_en), .uartTxStart(a_st), .uartTxIn(a_tin),
        .uartTxBusy(ub_a), .uartTxDone(ud_a), .grantId(a_gid), .busy(a_bsy), .timeoutErr(a_err)
    );

    uart_tx_arbiter #(.NUM_REQ(N), .BURST_LEN(BL_B), .START_TIMEOUT(TO)) dut_b (
        .clk(clk), .rstn(rstn), .enable(enable), .reqValid(req_vld), .reqData(req_dat),
        .reqReady(b_rdy), .uartTxEn(b_en), .uartTxStart(b_st), .uartTxIn(b_tin),
        .uartTxBusy(ub_b), .uartTxDone(ud_b), .grantId(b_gid), .busy(b_bsy), .timeoutErr(b_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    // Far-end UART: accepts txStart when idle, stays busy FRAME cycles, pulses done at the end.
    always @(posedge clk) begin
        #2;
        ud_a = 1'b0;
        if (!rstn) begin
            ub_a = 1'b0; left_a = 0;
        end else if (left_a > 0) begin
            left_a--;
            if (left_a == 0) begin ub_a = 1'b0; ud_a = 1'b1; end
        end else if (a_st && !dead) begin
            left_a = FRAME; ub_a = 1'b1; rx_a.push_back(a_tin);
        end
    end

    always @(posedge clk) begin
        #2;
        ud_b = 1'b0;
        if (!rstn) begin
            ub_b = 1'b0; left_b = 0;
        end else if (left_b > 0) begin
            left_b--;
            if (left_b == 0) begin ub_b = 1'b0; ud_b = 1'b1; end
        end else if (b_st && !dead) begin
            left_b = FRAME; ub_b = 1'b1; rx_b.push_back(b_tin);
        end
    end

    // ph: 0 waiting for a request, 1 start raised, 2 frame on the line.
    task automatic model_step(input int m, input logic bsy);
        int  w;
        int  lim;
        bit  cont;
        lim = (m == 0) ? BL_A : BL_B;
        if (!rstn) begin
            ph[m] = 0; ptr[m] = 0; run[m] = 0; own[m] = 0; age[m] = 0;
            m_dat[m] = '0; m_rdy[m] = '0; m_st[m] = 1'b0; m_err[m] = 1'b0; m_en[m] = 1'b0;
        end else begin
            m_rdy[m] = '0;
            m_en[m]  = enable;
            if (ph[m] == 0) begin
                if (enable && (req_vld != 0)) begin
                    cont = (run[m] > 0) && (run[m] < lim) && req_vld[own[m]];
                    if (cont) begin
                        w = own[m]; run[m]++;
                    end else begin
                        w = pick(req_vld, ptr[m]); run[m] = 1; ptr[m] = (w + 1) % N;
                    end
                    own[m] = w; m_dat[m] = req_dat[8*w +: 8]; m_rdy[m] = 4'(1 << w);
                    ph[m] = 1; age[m] = 0; m_st[m] = 1'b1;
                end else if (!req_vld[own[m]]) begin
                    run[m] = 0;
                end
            end else if (ph[m] == 1) begin
                if (bsy) begin
                    m_st[m] = 1'b0; ph[m] = 2;
                end else if (!enable) begin
                    m_st[m] = 1'b0; ph[m] = 0;
                end else if (age[m] == TO - 1) begin
                    m_err[m] = 1'b1; m_st[m] = 1'b0; ph[m] = 0;
                end else begin
                    age[m]++;
                end
            end else begin
                if (!bsy) ph[m] = 0;
            end
        end
    endtask

    // Single compare process: advance the model on the edge, check the DUTs half a cycle later.
    always begin
        @(posedge clk);
        model_step(0, ub_a);
        model_step(1, ub_b);
        @(negedge clk);
        chk("a.reqReady", a_rdy, m_rdy[0]);   chk("b.reqReady", b_rdy, m_rdy[1]);
        chk("a.txEn", a_en, m_en[0]);         chk("b.txEn", b_en, m_en[1]);
        chk("a.txStart", a_st, m_st[0]);      chk("b.txStart", b_st, m_st[1]);
        chk("a.txIn", a_tin, m_dat[0]);       chk("b.txIn", b_tin, m_dat[1]);
        chk("a.grantId", a_gid, own[0]);      chk("b.grantId", b_gid, own[1]);
        chk("a.busy", a_bsy, (ph[0] != 0));   chk("b.busy", b_bsy, (ph[1] != 0));
        chk("a.timeoutErr", a_err, m_err[0]); chk("b.timeoutErr", b_err, m_err[1]);
        if (a_rdy != 0) log_a.push_back(int'(a_gid));
        if (b_rdy != 0) log_b.push_back(int'(b_gid));
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        int cnt;
        int exp_rr[8]    = '{0, 1, 2, 3, 0, 1, 2, 3};
        int exp_burst[7] = '{1, 1, 1, 2, 2, 2, 1};
        int exp_wrap[3]  = '{3, 0, 3};

        // Power-on reset values
        repeat (3) tick();
        chk("rst.reqReady", a_rdy, 0); chk("rst.txStart", a_st, 0); chk("rst.txIn", a_tin, 0);
        chk("rst.grantId", a_gid, 0);  chk("rst.busy", a_bsy, 0);   chk("rst.timeoutErr", a_err, 0);
        chk("rst.txEn", a_en, 0);

        // Pure round-robin with everyone valid
        rstn = 1'b1; enable = 1'b1; req_vld = 4'b1111;
        n = 0;
        while (log_a.size() < 8 && n < 300) begin tick(); n++; end
        chk("rr.frames_seen", (log_a.size() >= 8) ? 1 : 0, 1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("rr.grant%0d", i), (i < log_a.size()) ? log_a[i] : -1, exp_rr[i]);
            chk($sformatf("rr.byte%0d", i), (i < rx_a.size()) ? int'(rx_a[i]) : -1, 8'hA0 + exp_rr[i]);
        end

        // Reset in the middle of a frame
        n = 0;
        while (!(a_bsy && ub_a && !a_st) && n < 50) begin tick(); n++; end
        chk("midrst.in_send", (a_bsy && !a_st) ? 1 : 0, 1);
        rstn = 1'b0; req_vld = 4'b0110;
        tick();
        chk("midrst.reqReady", a_rdy, 0); chk("midrst.txStart", a_st, 0); chk("midrst.txIn", a_tin, 0);
        chk("midrst.grantId", a_gid, 0);  chk("midrst.busy", a_bsy, 0);   chk("midrst.txEn", a_en, 0);
        tick(); tick();
        rstn = 1'b1;

        // Burst of three alternating between requesters 1 and 2
        base = log_b.size();
        n = 0;
        while (log_b.size() < base + 7 && n < 300) begin tick(); n++; end
        for (int i = 0; i < 7; i++)
            chk($sformatf("burst.grant%0d", i), (base + i < log_b.size()) ? log_b[base + i] : -1, exp_burst[i]);

        // Pointer wrap: after requester 3 is served, requester 0 comes next
        req_vld = 4'b1000;
        tick();
        base = log_a.size();
        n = 0;
        while (log_a.size() <= base && n < 100) begin tick(); n++; end
        req_vld = 4'b1001;
        n = 0;
        while (log_a.size() < base + 3 && n < 200) begin tick(); n++; end
        for (int i = 0; i < 3; i++)
            chk($sformatf("wrap.grant%0d", i), (base + i < log_a.size()) ? log_a[base + i] : -1, exp_wrap[i]);

        // Enable dropped while waiting for txBusy
        req_vld = '0;
        n = 0;
        while ((a_bsy || b_bsy) && n < 50) begin tick(); n++; end
        dead = 1'b1; req_vld = 4'b0001;
        n = 0;
        while (!a_st && n < 10) begin tick(); n++; end
        chk("endrop.start_seen", a_st, 1);
        tick(); tick();
        enable = 1'b0;
        tick();
        chk("endrop.txStart", a_st, 0); chk("endrop.busy", a_bsy, 0); chk("endrop.timeoutErr", a_err, 0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin tick(); if (a_rdy != 0) cnt++; end
        chk("endrop.no_ready", cnt, 0); chk("endrop.timeoutErr_late", a_err, 0);

        // Enable dropped while the frame is on the line
        dead = 1'b0; base = rx_a.size(); enable = 1'b1;
        n = 0;
        while (!(a_bsy && ub_a && !a_st) && n < 20) begin tick(); n++; end
        enable = 1'b0;
        n = 0;
        while (a_bsy && n < 20) begin tick(); n++; end
        chk("sendrop.frame_done", rx_a.size() - base, 1);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin tick(); if (a_rdy != 0) cnt++; end
        chk("sendrop.no_ready", cnt, 0);
        enable = 1'b1;
        n = 0;
        while (a_rdy == 0 && n < 10) begin tick(); n++; end
        chk("sendrop.ready_after_enable", a_rdy, 4'b0001);

        // Start timeout with txBusy stuck low
        req_vld = '0;
        n = 0;
        while ((a_bsy || b_bsy) && n < 50) begin tick(); n++; end
        dead = 1'b1; req_vld = 4'b0001;
        n = 0;
        while (!a_st && n < 10) begin tick(); n++; end
        cnt = 0;
        while (a_st && cnt < 40) begin cnt++; tick(); end
        chk("tmo.start_len", cnt, 16);
        chk("tmo.timeoutErr", a_err, 1);
        chk("tmo.busy", a_bsy, 0);
        dead = 1'b0; base = rx_a.size();
        n = 0;
        while (rx_a.size() <= base && n < 30) begin tick(); n++; end
        chk("tmo.next_byte", (rx_a.size() > base) ? int'(rx_a[base]) : -1, 8'hA0);
        req_vld = '0;
        repeat (12) tick();
        chk("tmo.err_sticky", a_err, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
